// File: rtl/serial_bus_port_if.sv
// Bus bundle for serial_bus_port: transmit channels, the narrow Arduino
// byte bus in both directions, and the receive-side valid/ready hand-off.
interface serial_bus_port_if #(
  parameter int DATA_W = 16,
  parameter int BUS_W  = 8,
  parameter int N_CH   = 3
);
  logic [N_CH-1:0]        tx_req;
  logic [N_CH*DATA_W-1:0] tx_data;
  logic [N_CH-1:0]        tx_ack;
  logic                   ard_receive_ready;
  logic [BUS_W-1:0]       out_bus;
  logic [N_CH-1:0]        bus_sel;
  logic                   tx_busy;
  logic                   ard_data_ready;
  logic [BUS_W-1:0]       in_bus;
  logic [DATA_W-1:0]      rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic                   rx_overrun;

  // The port block itself
  modport slave (
    input  tx_req, tx_data, ard_receive_ready, ard_data_ready, in_bus, rx_ready,
    output tx_ack, out_bus, bus_sel, tx_busy, rx_data, rx_valid, rx_overrun
  );

  // Core datapath / Arduino side
  modport master (
    output tx_req, tx_data, ard_receive_ready, ard_data_ready, in_bus, rx_ready,
    input  tx_ack, out_bus, bus_sel, tx_busy, rx_data, rx_valid, rx_overrun
  );
endinterface

// File: rtl/serial_bus_port.sv
// N-channel serializer/deserializer between wide core words and the narrow
// Arduino byte bus. Transmit side: round-robin arbiter feeding a shift
// register, MSB beat first, with a one-cycle ack per word. Receive side:
// beat assembler with valid/ready hand-off and a sticky overrun flag.
module serial_bus_port #(
  parameter int DATA_W = 16,
  parameter int BUS_W  = 8,
  parameter int N_CH   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  serial_bus_port_if.slave   bus
);

  localparam int BEATS = DATA_W / BUS_W;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((DATA_W % BUS_W) != 0 || DATA_W < BUS_W) begin : g_bad_width
    $error("serial_bus_port: DATA_W must be a non-zero multiple of BUS_W");
  end
  if (N_CH < 1) begin : g_bad_nch
    $error("serial_bus_port: N_CH must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, SEND, ACK} tx_state_t;

  // ---------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------
  tx_state_t         state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]  beat_reg, beat_next;
  logic [CH_W-1:0]   last_grant_reg, last_grant_next;

  logic [DATA_W-1:0] ch_word [N_CH];
  logic [N_CH-1:0]   grant_onehot;
  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   cand;

  logic [BUS_W-1:0]  tx_out_bus;
  logic [N_CH-1:0]   tx_bus_sel;
  logic [N_CH-1:0]   tx_ack_pulse;
  logic              tx_busy_flag;

  // Split the flat channel vector into words; last_grant doubles as the
  // owner of the word in flight, so its one-hot drives bus_sel and tx_ack.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign ch_word[gi]      = bus.tx_data[gi*DATA_W +: DATA_W];
    assign grant_onehot[gi] = (last_grant_reg == CH_W'(gi));
  end

  // Round-robin search: first requester strictly after last_grant, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_reg;
    cand        = last_grant_reg;
    for (int i = 1; i <= N_CH; i++) begin
      cand = CH_W'((int'(last_grant_reg) + i) % N_CH);
      if (!grant_found && bus.tx_req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // TX next-state and bus outputs; outputs depend on state only so the
  // Arduino sees a stable beat for as long as it stalls
  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    beat_next       = beat_reg;
    last_grant_next = last_grant_reg;
    tx_out_bus      = '0;
    tx_bus_sel      = '0;
    tx_ack_pulse    = '0;
    tx_busy_flag    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          shift_next      = ch_word[grant_idx];
          last_grant_next = grant_idx;
          beat_next       = '0;
          state_next      = SEND;
        end
      end
      SEND: begin
        tx_out_bus   = shift_reg[DATA_W-1 -: BUS_W];
        tx_bus_sel   = grant_onehot;
        tx_busy_flag = 1'b1;
        if (bus.ard_receive_ready) begin
          if (beat_reg == CNT_W'(BEATS-1)) begin
            state_next = ACK;
          end else begin
            shift_next = shift_reg << BUS_W;
            beat_next  = beat_reg + CNT_W'(1);
          end
        end
      end
      ACK: begin
        tx_ack_pulse = grant_onehot;
        tx_busy_flag = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort wins over everything; last_grant is kept so a lingering
    // request is re-arbitrated from the following channel.
    if (flush) begin
      state_next      = IDLE;
      shift_next      = shift_reg;
      beat_next       = '0;
      last_grant_next = last_grant_reg;
    end
  end

  // TX state register; reset points last_grant at the top channel so
  // channel 0 is the first to win
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      beat_reg       <= '0;
      last_grant_reg <= CH_W'(N_CH-1);
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      beat_reg       <= beat_next;
      last_grant_reg <= last_grant_next;
    end
  end

  assign bus.out_bus = tx_out_bus;
  assign bus.bus_sel = tx_bus_sel;
  assign bus.tx_ack  = tx_ack_pulse;
  assign bus.tx_busy = tx_busy_flag;

  // ---------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]  rx_cnt_reg;
  logic [DATA_W-1:0] rx_data_reg;
  logic              rx_valid_reg;
  logic              rx_overrun_reg;
  logic [DATA_W-1:0] rx_word;
  logic              rx_done;
  logic              rx_take;

  if (BEATS == 1) begin : g_rx_single
    // Every beat is a whole word
    assign rx_word = bus.in_bus;
  end else begin : g_rx_multi
    // Only the earlier beats need storage; the final beat comes straight
    // from in_bus into the delivered word.
    logic [DATA_W-BUS_W-1:0] rx_shift_reg;

    // Shift in beats, first beat ending up as the MSB of the word
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rx_shift_reg <= '0;
      end else if (bus.ard_data_ready && !flush) begin
        rx_shift_reg <= rx_word[DATA_W-BUS_W-1:0];
      end
    end

    assign rx_word = {rx_shift_reg, bus.in_bus};
  end

  assign rx_done = bus.ard_data_ready && (rx_cnt_reg == CNT_W'(BEATS-1));
  assign rx_take = rx_valid_reg && bus.rx_ready;

  // Beat counting and word hand-off; a completed word is dropped (and the
  // overrun flag latched) only if the previous one is still unconsumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt_reg     <= '0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else if (flush) begin
      rx_cnt_reg     <= '0;
      rx_valid_reg   <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      if (bus.ard_data_ready) begin
        rx_cnt_reg <= rx_done ? '0 : rx_cnt_reg + CNT_W'(1);
      end
      if (rx_done) begin
        if (!rx_valid_reg || rx_take) begin
          rx_data_reg  <= rx_word;
          rx_valid_reg <= 1'b1;
        end else begin
          rx_overrun_reg <= 1'b1;
        end
      end else if (rx_take) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.rx_data    = rx_data_reg;
  assign bus.rx_valid   = rx_valid_reg;
  assign bus.rx_overrun = rx_overrun_reg;

endmodule

// File: tb/tb_serial_bus_port.sv
// Self-checking bench for serial_bus_port: a cycle table for the basic
// word/stall sequence, hand-written reset/RX/flush sequences, and a long
// random run checked against a transaction-level model.
module tb_serial_bus_port;
  localparam int DATA_W = 16;
  localparam int BUS_W  = 8;
  localparam int N_CH   = 3;
  localparam int BEATS  = DATA_W / BUS_W;
  localparam int N_VEC  = 14;
  localparam int N_RND  = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  serial_bus_port_if #(.DATA_W(DATA_W), .BUS_W(BUS_W), .N_CH(N_CH)) bus ();

  serial_bus_port #(.DATA_W(DATA_W), .BUS_W(BUS_W), .N_CH(N_CH)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N_CH-1:0]  req;
    logic             rdy;
    logic [BUS_W-1:0] e_out;
    logic [N_CH-1:0]  e_sel;
    logic [N_CH-1:0]  e_ack;
    logic             e_busy;
  } vec_t;

  vec_t vt [N_VEC];

  // reference model state for the random run
  int               m_last;
  int               m_ch;
  bit               m_send;
  bit               m_ack;
  logic [BUS_W-1:0] m_q [$];
  logic [BUS_W-1:0] r_q [$];
  logic [DATA_W-1:0] m_rdata;
  bit               m_rvalid;
  bit               m_ovr;
  logic [BUS_W-1:0] e_out;
  logic [N_CH-1:0]  e_sel;
  logic [N_CH-1:0]  e_ack;
  logic             e_busy;
  logic [DATA_W-1:0] w;
  bit               take;
  bit               picked;
  int               c;
  int               tx_words;
  int               rx_words;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int ch, input logic [DATA_W-1:0] word);
    bus.tx_data[ch*DATA_W +: DATA_W] = word;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0;
    bus.tx_req = '0;
    bus.ard_receive_ready = 1'b0;
    bus.ard_data_ready = 1'b0;
    bus.rx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic chk_tx(input string tag, input logic [BUS_W-1:0] o, input logic [N_CH-1:0] s,
                        input logic [N_CH-1:0] a, input logic b);
    chk({tag, " out_bus"}, 32'(bus.out_bus), 32'(o));
    chk({tag, " bus_sel"}, 32'(bus.bus_sel), 32'(s));
    chk({tag, " tx_ack"},  32'(bus.tx_ack),  32'(a));
    chk({tag, " tx_busy"}, 32'(bus.tx_busy), 32'(b));
  endtask

  initial begin
    bus.tx_req = '0;
    bus.tx_data = '0;
    bus.ard_receive_ready = 1'b0;
    bus.ard_data_ready = 1'b0;
    bus.in_bus = '0;
    bus.rx_ready = 1'b0;

    // word A5C3 on channel 1: stalled 3 cycles on the first beat, then
    // sent again without stalls
    vt[0]  = '{3'b010, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0};
    vt[1]  = '{3'b010, 1'b0, 8'hA5, 3'b010, 3'b000, 1'b1};
    vt[2]  = '{3'b010, 1'b0, 8'hA5, 3'b010, 3'b000, 1'b1};
    vt[3]  = '{3'b010, 1'b0, 8'hA5, 3'b010, 3'b000, 1'b1};
    vt[4]  = '{3'b010, 1'b1, 8'hA5, 3'b010, 3'b000, 1'b1};
    vt[5]  = '{3'b010, 1'b1, 8'hC3, 3'b010, 3'b000, 1'b1};
    vt[6]  = '{3'b010, 1'b1, 8'h00, 3'b000, 3'b010, 1'b1};
    vt[7]  = '{3'b000, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0};
    vt[8]  = '{3'b000, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0};
    vt[9]  = '{3'b010, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0};
    vt[10] = '{3'b010, 1'b1, 8'hA5, 3'b010, 3'b000, 1'b1};
    vt[11] = '{3'b010, 1'b1, 8'hC3, 3'b010, 3'b000, 1'b1};
    vt[12] = '{3'b010, 1'b1, 8'h00, 3'b000, 3'b010, 1'b1};
    vt[13] = '{3'b000, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0};

    // ---- reset state, asserted between clock edges ----
    #2 rst = 1'b0;
    #1;
    chk_tx("reset", 8'h00, 3'b000, 3'b000, 1'b0);
    chk("reset rx_data", 32'(bus.rx_data), 32'h0);
    chk("reset rx_valid", 32'(bus.rx_valid), 32'h0);
    chk("reset rx_overrun", 32'(bus.rx_overrun), 32'h0);
    tick();
    tick();
    rst = 1'b1;

    // ---- table-driven single word with stall ----
    set_word(0, 16'h1111);
    set_word(1, 16'hA5C3);
    set_word(2, 16'h2222);
    for (int i = 0; i < N_VEC; i++) begin
      if (i == 2) set_word(1, 16'h0000);   // after grant: must be ignored
      if (i == 8) set_word(1, 16'hA5C3);
      bus.tx_req = vt[i].req;
      bus.ard_receive_ready = vt[i].rdy;
      chk_tx($sformatf("vec%0d", i), vt[i].e_out, vt[i].e_sel, vt[i].e_ack, vt[i].e_busy);
      tick();
    end
    $display("table: %0d cycles applied", N_VEC);

    // ---- asynchronous reset in the middle of a word ----
    set_word(0, 16'h0F1E);
    set_word(2, 16'h1357);
    bus.tx_req = 3'b100;
    bus.ard_receive_ready = 1'b0;
    tick();
    chk_tx("pre-reset", 8'h13, 3'b100, 3'b000, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_tx("mid-word reset", 8'h00, 3'b000, 3'b000, 1'b0);
    bus.tx_req = '0;
    tick();
    tick();
    rst = 1'b1;
    bus.tx_req = 3'b111;
    tick();
    chk_tx("first grant after reset", 8'h0F, 3'b001, 3'b000, 1'b1);
    $display("reset: mid-word abort, channel 0 granted first");
    do_reset();

    // ---- receive assembly, overrun and consume ----
    bus.rx_ready = 1'b0;
    bus.ard_data_ready = 1'b1;
    bus.in_bus = 8'h12;
    tick();
    bus.in_bus = 8'h34;
    tick();
    bus.ard_data_ready = 1'b0;
    chk("rx word1 data", 32'(bus.rx_data), 32'h1234);
    chk("rx word1 valid", 32'(bus.rx_valid), 32'h1);
    chk("rx word1 overrun", 32'(bus.rx_overrun), 32'h0);
    bus.ard_data_ready = 1'b1;
    bus.in_bus = 8'h56;
    tick();
    bus.in_bus = 8'h78;
    tick();
    bus.ard_data_ready = 1'b0;
    chk("rx overrun set", 32'(bus.rx_overrun), 32'h1);
    chk("rx data kept", 32'(bus.rx_data), 32'h1234);
    chk("rx valid kept", 32'(bus.rx_valid), 32'h1);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    chk("rx consumed valid", 32'(bus.rx_valid), 32'h0);
    chk("rx overrun sticky", 32'(bus.rx_overrun), 32'h1);
    $display("rx: 1234 delivered, 5678 dropped with overrun");

    // ---- flush mid-word on channel 2, RX partial beat discarded ----
    set_word(2, 16'hBEEF);
    bus.tx_req = 3'b100;
    bus.ard_receive_ready = 1'b1;
    bus.ard_data_ready = 1'b1;
    bus.in_bus = 8'hAA;
    tick();
    chk_tx("flush beat1", 8'hBE, 3'b100, 3'b000, 1'b1);
    bus.in_bus = 8'hBB;
    tick();
    bus.ard_receive_ready = 1'b0;
    chk_tx("flush beat2", 8'hEF, 3'b100, 3'b000, 1'b1);
    chk("flush pre rx_data", 32'(bus.rx_data), 32'hAABB);
    chk("flush pre rx_valid", 32'(bus.rx_valid), 32'h1);
    bus.in_bus = 8'hCC;
    tick();
    chk_tx("flush stall", 8'hEF, 3'b100, 3'b000, 1'b1);
    bus.ard_receive_ready = 1'b1;
    bus.ard_data_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_tx("after flush", 8'h00, 3'b000, 3'b000, 1'b0);
    chk("flush rx_valid", 32'(bus.rx_valid), 32'h0);
    chk("flush rx_overrun", 32'(bus.rx_overrun), 32'h0);
    bus.ard_data_ready = 1'b1;
    bus.in_bus = 8'hDD;
    tick();
    chk_tx("regrant beat1", 8'hBE, 3'b100, 3'b000, 1'b1);
    bus.in_bus = 8'hEE;
    tick();
    bus.ard_data_ready = 1'b0;
    chk_tx("regrant beat2", 8'hEF, 3'b100, 3'b000, 1'b1);
    chk("flush rx_cnt cleared", 32'(bus.rx_data), 32'hDDEE);
    tick();
    chk_tx("regrant ack", 8'h00, 3'b000, 3'b100, 1'b1);
    bus.tx_req = '0;
    tick();
    chk_tx("regrant idle", 8'h00, 3'b000, 3'b000, 1'b0);
    $display("flush: BEEF aborted, re-sent and acked once");

    // ---- randomized run against the transaction model ----
    do_reset();
    m_last = N_CH - 1;
    m_ch = 0;
    m_send = 0;
    m_ack = 0;
    m_q.delete();
    r_q.delete();
    m_rdata = '0;
    m_rvalid = 0;
    m_ovr = 0;
    tx_words = 0;
    rx_words = 0;
    for (int cyc = 0; cyc < N_RND; cyc++) begin
      e_out = '0;
      e_sel = '0;
      e_ack = '0;
      e_busy = 1'b0;
      if (m_ack) begin
        e_ack = N_CH'(1) << m_ch;
        e_busy = 1'b1;
      end else if (m_send) begin
        e_out = m_q[0];
        e_sel = N_CH'(1) << m_ch;
        e_busy = 1'b1;
      end
      chk_tx("rnd", e_out, e_sel, e_ack, e_busy);
      chk("rnd rx_data", 32'(bus.rx_data), 32'(m_rdata));
      chk("rnd rx_valid", 32'(bus.rx_valid), 32'(m_rvalid));
      chk("rnd rx_overrun", 32'(bus.rx_overrun), 32'(m_ovr));

      // requesters hold until they see their ack
      for (int k = 0; k < N_CH; k++) begin
        if (bus.tx_ack[k]) bus.tx_req[k] = 1'b0;
        else if (!bus.tx_req[k] && $urandom_range(3) == 0) bus.tx_req[k] = 1'b1;
        set_word(k, DATA_W'($urandom));
      end
      bus.ard_receive_ready = ($urandom_range(2) != 0);
      bus.ard_data_ready = ($urandom_range(1) != 0);
      bus.in_bus = BUS_W'($urandom);
      bus.rx_ready = ($urandom_range(2) == 0);
      flush = ($urandom_range(80) == 0);

      if (flush) begin
        m_send = 0;
        m_ack = 0;
        m_q.delete();
        r_q.delete();
        m_rvalid = 0;
        m_ovr = 0;
      end else begin
        if (m_ack) begin
          m_ack = 0;
          tx_words++;
          $display("tx word %0d done on channel %0d", tx_words, m_ch);
        end else if (m_send) begin
          if (bus.ard_receive_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
              m_send = 0;
              m_ack = 1;
            end
          end
        end else if (bus.tx_req != '0) begin
          picked = 0;
          for (int k = 1; k <= N_CH; k++) begin
            c = (m_last + k) % N_CH;
            if (!picked && bus.tx_req[c]) begin
              picked = 1;
              m_ch = c;
            end
          end
          m_last = m_ch;
          w = bus.tx_data[m_ch*DATA_W +: DATA_W];
          for (int b = 0; b < BEATS; b++) m_q.push_back(BUS_W'(w >> (BUS_W * (BEATS - 1 - b))));
          m_send = 1;
        end

        take = m_rvalid && bus.rx_ready;
        if (bus.ard_data_ready) r_q.push_back(bus.in_bus);
        if (r_q.size() == BEATS) begin
          w = '0;
          for (int b = 0; b < BEATS; b++) w = (w << BUS_W) | DATA_W'(r_q[b]);
          r_q.delete();
          if (!m_rvalid || take) begin
            m_rdata = w;
            m_rvalid = 1;
            rx_words++;
            $display("rx word %0d = 0x%04h", rx_words, w);
          end else begin
            m_ovr = 1;
          end
        end else if (take) begin
          m_rvalid = 0;
        end
      end
      tick();
    end
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
